// File: rtl/risk_gate_multi.sv
// Pre-trade risk gate: per-symbol position limit, global open-exposure limit and sticky halt.
// Optional approval rate limiting is compiled in with `define RISK_RATE_LIMIT_EN.
module risk_gate_multi #(
  parameter int SYM_W    = 3,
  parameter int QTY_W    = 16,
  parameter int PX_W     = 16,
  parameter int POS_W    = 32,
  parameter int EXP_W    = 48,
  parameter int RATE_WIN = 1024,
  parameter int RATE_MAX = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SYM_W-1:0]        req_sym,
  input  logic                    req_side,
  input  logic [QTY_W-1:0]        req_qty,
  input  logic [PX_W-1:0]         req_px,
  output logic                    resp_valid,
  output logic                    resp_approved,
  output logic [2:0]              resp_reason,
  output logic [SYM_W-1:0]        resp_sym,
  input  logic                    fill_valid,
  input  logic [SYM_W-1:0]        fill_sym,
  input  logic                    fill_side,
  input  logic [QTY_W-1:0]        fill_qty,
  input  logic [PX_W-1:0]         fill_px,
  input  logic [POS_W-2:0]        pos_limit,
  input  logic [EXP_W-1:0]        exp_limit,
  input  logic                    kill,
  output logic                    halted,
  input  logic [SYM_W-1:0]        rd_sym,
  output logic signed [POS_W-1:0] rd_pos,
  output logic [EXP_W-1:0]        exposure
);
  localparam int NUM_SYM = 2**SYM_W;
  localparam int NOT_W   = QTY_W + PX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] R_OK       = 3'd0;
  localparam logic [2:0] R_HALTED   = 3'd1;
  localparam logic [2:0] R_POSITION = 3'd2;
  localparam logic [2:0] R_EXPOSURE = 3'd3;
  localparam logic [2:0] R_RATE     = 3'd4;

  logic [1:0]                state_reg, state_next;
  logic                      ready_reg;
  logic [SYM_W-1:0]          sym_reg;
  logic                      side_reg;
  logic [QTY_W-1:0]          qty_reg;
  logic [PX_W-1:0]           px_reg;
  logic signed [POS_W-1:0]   pos_snap_reg;
  logic [EXP_W-1:0]          exposure_reg, exposure_next;
  logic                      halted_reg;
  logic                      resp_valid_reg, resp_approved_reg;
  logic [2:0]                resp_reason_reg;
  logic [SYM_W-1:0]          resp_sym_reg;
  logic [NUM_SYM-1:0][POS_W-1:0] pos_flat;

  logic                      accept;
  logic                      rate_hit;
  logic [NOT_W-1:0]          notional, fill_notional;
  logic signed [POS_W:0]     qty_ext, proj;
  logic [POS_W:0]            proj_abs, limit_ext;
  logic [EXP_W:0]            exp_check, exp_base, fill_ext, exp_diff;
  logic [2:0]                reason_calc;
  logic                      approve_commit;
  logic signed [POS_W:0]     fill_cur_ext, fill_qty_ext, fill_sum, fill_new_ext;
  logic signed [POS_W-1:0]   fill_pos_new;
  logic [POS_W:0]            fill_abs;
  logic                      fill_breach;

  assign accept    = req_valid && ready_reg;
  assign limit_ext = {2'b00, pos_limit};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_CALC;
      S_CALC:  state_next = S_RESP;
      default: state_next = S_IDLE;
    endcase
  end

  // Request check: works only on operands and the position captured at acceptance.
  always_comb begin
    notional  = NOT_W'(qty_reg) * NOT_W'(px_reg);
    qty_ext   = $signed({{(POS_W + 1 - QTY_W){1'b0}}, qty_reg});
    proj      = side_reg ? ($signed({pos_snap_reg[POS_W-1], pos_snap_reg}) - qty_ext)
                         : ($signed({pos_snap_reg[POS_W-1], pos_snap_reg}) + qty_ext);
    proj_abs  = proj[POS_W] ? (-proj) : proj;
    exp_check = {1'b0, exposure_reg} + (EXP_W + 1)'(notional);
    if (halted_reg)                      reason_calc = R_HALTED;
    else if (proj_abs > limit_ext)       reason_calc = R_POSITION;
    else if (exp_check > {1'b0, exp_limit}) reason_calc = R_EXPOSURE;
    else if (rate_hit)                   reason_calc = R_RATE;
    else                                 reason_calc = R_OK;
    approve_commit = (state_reg == S_CALC) && (reason_calc == R_OK);
  end

  // Fill path: saturating position update and breach detection on the result.
  always_comb begin
    fill_notional = NOT_W'(fill_qty) * NOT_W'(fill_px);
    fill_cur_ext  = $signed({pos_flat[fill_sym][POS_W-1], pos_flat[fill_sym]});
    fill_qty_ext  = $signed({{(POS_W + 1 - QTY_W){1'b0}}, fill_qty});
    fill_sum      = fill_side ? (fill_cur_ext - fill_qty_ext) : (fill_cur_ext + fill_qty_ext);
    if (fill_sum[POS_W] != fill_sum[POS_W-1])
      fill_pos_new = fill_sum[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    else
      fill_pos_new = fill_sum[POS_W-1:0];
    fill_new_ext = {fill_pos_new[POS_W-1], fill_pos_new};
    fill_abs     = fill_new_ext[POS_W] ? (-fill_new_ext) : fill_new_ext;
    fill_breach  = fill_valid && (fill_abs > limit_ext);
  end

  // Reservation and retirement may land on the same edge; floor at 0, clamp at max.
  always_comb begin
    exp_base = {1'b0, exposure_reg} + (approve_commit ? (EXP_W + 1)'(notional) : '0);
    fill_ext = fill_valid ? (EXP_W + 1)'(fill_notional) : '0;
    exp_diff = exp_base - fill_ext;
    if (exp_base < fill_ext)  exposure_next = '0;
    else if (exp_diff[EXP_W]) exposure_next = '1;
    else                      exposure_next = exp_diff[EXP_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      ready_reg         <= 1'b0;
      sym_reg           <= '0;
      side_reg          <= 1'b0;
      qty_reg           <= '0;
      px_reg            <= '0;
      pos_snap_reg      <= '0;
      exposure_reg      <= '0;
      halted_reg        <= 1'b0;
      resp_valid_reg    <= 1'b0;
      resp_approved_reg <= 1'b0;
      resp_reason_reg   <= R_OK;
      resp_sym_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= (state_next == S_IDLE);
      exposure_reg   <= exposure_next;
      resp_valid_reg <= 1'b0;
      if (kill || fill_breach) halted_reg <= 1'b1;
      if (state_reg == S_IDLE && accept) begin
        sym_reg      <= req_sym;
        side_reg     <= req_side;
        qty_reg      <= req_qty;
        px_reg       <= req_px;
        pos_snap_reg <= pos_flat[req_sym];
      end
      if (state_reg == S_CALC) begin
        resp_valid_reg    <= 1'b1;
        resp_approved_reg <= (reason_calc == R_OK);
        resp_reason_reg   <= reason_calc;
        resp_sym_reg      <= sym_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym
      logic signed [POS_W-1:0] pos_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pos_q <= '0;
        else if (fill_valid && fill_sym == SYM_W'(gi)) pos_q <= fill_pos_new;
      end
      assign pos_flat[gi] = pos_q;
    end
  endgenerate

`ifdef RISK_RATE_LIMIT_EN
  localparam int WIN_W = $clog2(RATE_WIN);
  localparam int CNT_W = $clog2(RATE_MAX + 1);
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] appr_cnt_reg;
  logic             win_wrap;

  assign win_wrap = (win_cnt_reg == WIN_W'(RATE_WIN - 1));
  assign rate_hit = (appr_cnt_reg == CNT_W'(RATE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_reg  <= '0;
      appr_cnt_reg <= '0;
    end else begin
      win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + 1'b1;
      // An approval landing on the wrap edge counts toward the new window.
      if (win_wrap)            appr_cnt_reg <= approve_commit ? CNT_W'(1) : '0;
      else if (approve_commit) appr_cnt_reg <= appr_cnt_reg + 1'b1;
    end
  end
`else
  // Rate limiting compiled out: the window parameters have no effect.
  assign rate_hit = (RATE_WIN < 0) && (RATE_MAX < 0);
`endif

  assign req_ready     = ready_reg;
  assign resp_valid    = resp_valid_reg;
  assign resp_approved = resp_approved_reg;
  assign resp_reason   = resp_reason_reg;
  assign resp_sym      = resp_sym_reg;
  assign halted        = halted_reg;
  assign exposure      = exposure_reg;
  assign rd_pos        = pos_flat[rd_sym];

endmodule
